// File: rtl/cpu_mem_pkg.sv
// Shared constants and encodings for the CPU memory responder and its bench.
// Opcodes mirror the controller's instruction encoding so benches can decode images.
package cpu_mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } ld_state_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_e;

    // True when the pointer addresses the final word of the store.
    function automatic logic is_last_addr(input logic [ADDR_W-1:0] a);
        return a == ADDR_W'(DEPTH - 1);
    endfunction

endpackage

// File: rtl/cpu_mem_responder_mem_array.sv
// DEPTH x DATA_W register file: one write port, one registered read port.
// Contents and read register clear asynchronously on reset.
module mem_array #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Next-state for storage words and the read register; unread cycles hold rdata.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (we && (waddr == ADDR_W'(i))) ? wdata : mem_q[i];
        end
        rdata_d = re ? mem_q[raddr] : rdata_q;
    end

    // Storage and read register flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 8-bit RISC controller: boot loader, unified
// instruction/data store, CPU read/store port and sticky protocol-error flag.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DATA_W,
    parameter int DEPTH  = cpu_mem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic              data_e,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              bus_err
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic              ld_ready_q, ld_ready_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_done_q, load_done_d;
    logic              bus_err_q, bus_err_d;
    logic              rdata_valid_q, rdata_valid_d;

    logic              ld_accept_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              mem_re_s;

    assign ld_accept_s = ld_valid && ld_ready_q;

    // Loader/run sequencing, write-port steering and protocol checking.
    always_comb begin
        state_d       = state_q;
        load_ptr_d    = load_ptr_q;
        ld_ready_d    = ld_ready_q;
        cpu_hold_d    = cpu_hold_q;
        load_done_d   = load_done_q;
        bus_err_d     = bus_err_q;
        rdata_valid_d = 1'b0;
        mem_we_s      = 1'b0;
        mem_waddr_s   = addr;
        mem_wdata_s   = wdata;
        mem_re_s      = 1'b0;

        case (state_q)
            LOAD: begin
                ld_ready_d  = 1'b1;
                cpu_hold_d  = 1'b1;
                load_done_d = 1'b0;
                if (rd || wr) begin
                    bus_err_d = 1'b1;
                end else begin
                    bus_err_d = bus_err_q;
                end
                if (ld_accept_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = load_ptr_q;
                    mem_wdata_s = ld_data;
                    load_ptr_d  = load_ptr_q + ADDR_W'(1);
                    // The final slot ends loading even without ld_last: no wrap.
                    if (ld_last || is_last_addr(load_ptr_q)) begin
                        state_d     = RUN;
                        ld_ready_d  = 1'b0;
                        cpu_hold_d  = 1'b0;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    load_ptr_d = load_ptr_q;
                end
            end
            RUN: begin
                ld_ready_d  = 1'b0;
                cpu_hold_d  = 1'b0;
                load_done_d = 1'b1;
                if (rd && !wr) begin
                    mem_re_s      = 1'b1;
                    rdata_valid_d = 1'b1;
                end else if (wr && !rd && data_e) begin
                    mem_we_s = 1'b1;
                end else if (wr) begin
                    bus_err_d = 1'b1;
                end else begin
                    rdata_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = LOAD;
                ld_ready_d = 1'b0;
                cpu_hold_d = 1'b1;
            end
        endcase
    end

    // Control and status flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= LOAD;
            load_ptr_q    <= '0;
            ld_ready_q    <= 1'b0;
            cpu_hold_q    <= 1'b1;
            load_done_q   <= 1'b0;
            bus_err_q     <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            ld_ready_q    <= ld_ready_d;
            cpu_hold_q    <= cpu_hold_d;
            load_done_q   <= load_done_d;
            bus_err_q     <= bus_err_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk  (clk),
        .reset(reset),
        .we   (mem_we_s),
        .waddr(mem_waddr_s),
        .wdata(mem_wdata_s),
        .re   (mem_re_s),
        .raddr(addr),
        .rdata(rdata)
    );

    assign rdata_valid = rdata_valid_q;
    assign ld_ready    = ld_ready_q;
    assign cpu_hold    = cpu_hold_q;
    assign load_done   = load_done_q;
    assign bus_err     = bus_err_q;

endmodule
